serial_memory_loader: RTL

Host-link front end that sits directly upstream of the processor's external memory port and pause input. It takes bytes from a UART receiver and decodes framed commands. It loads or reads back words in memory over the external memory bus, and it controls processor pause/run. Responses return over a byte-wide TX handshake to the UART transmitter.

---
 rtl/serial_memory_loader_pkg.sv | 24 ++
 rtl/serial_memory_loader_byte_shift_assembler.sv | 35 +++
 rtl/serial_memory_loader.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/serial_memory_loader_pkg.sv
// Shared command codes, reply bytes and FSM state encoding for the host-link memory loader.
package serial_memory_loader_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] CMD_PAUSE = 8'h50;
  localparam logic [7:0] CMD_GO    = 8'h47;

  localparam logic [7:0] ACK_BYTE  = 8'h06;
  localparam logic [7:0] NAK_BYTE  = 8'h15;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_WRITE,
    ST_READ_ISSUE,
    ST_READ_CAPTURE,
    ST_SEND,
    ST_ACK,
    ST_NAK
  } loaderState_t;

endpackage

// File: rtl/serial_memory_loader_byte_shift_assembler.sv
// Four-byte MSB-first shift register with a byte counter; done marks the shift that completes a word.
module byte_shift_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        load,
  input  logic [31:0] loadValue,
  input  logic        shiftEn,
  input  logic [7:0]  shiftIn,
  output logic [31:0] word,
  output logic        done
);

  logic [1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word  <= '0;
      count <= '0;
    end else if (clear) begin
      word  <= '0;
      count <= '0;
    end else if (load) begin
      word  <= loadValue;
      count <= '0;
    end else if (shiftEn) begin
      word  <= {word[23:0], shiftIn};
      count <= count + 2'd1;
    end
  end

  // Count wraps to zero on the 4th shift, so the next field starts clean.
  assign done = shiftEn && !clear && !load && (count == 2'd3);

endmodule

// File: rtl/serial_memory_loader.sv
// Host-link front end: decodes framed UART commands into word loads/reads on the external
// memory port and pause/run control, replying over a byte-wide TX handshake.
//
// state           | meaning
// ST_IDLE         | waiting for a command byte
// ST_ADDR         | collecting 4 address bytes (timed)
// ST_DATA         | collecting 4 write-data bytes (timed)
// ST_WRITE        | single-cycle word write on the external bus
// ST_READ_ISSUE   | read mode asserted, memory producing data
// ST_READ_CAPTURE | read data registered into the reply word
// ST_SEND         | streaming 4 reply bytes, MSB first
// ST_ACK / ST_NAK | presenting 0x06 / 0x15 until accepted
module serial_memory_loader
  import serial_memory_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter bit          START_PAUSED   = 1'b1,
  parameter logic [2:0]  MODE_NONE      = 3'd0,
  parameter logic [2:0]  MODE_WORD      = 3'd3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rxData,
  input  logic        rxValid,
  output logic [7:0]  txData,
  output logic        txValid,
  input  logic        txReady,
  output logic        pause,
  output logic        externalMemoryControl,
  output logic [31:0] externalAddress,
  output logic [31:0] externalData,
  output logic [2:0]  externalReadMode,
  output logic [2:0]  externalWriteMode,
  input  logic [31:0] externalDataOut,
  output logic        busy,
  output logic        overrun
);

  localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(TIMEOUT_CYCLES - 1);

  loaderState_t       state;
  logic [TIMER_W-1:0] timer;
  logic               isWrite;

  logic        frameStart;
  logic        addrShift, addrDone;
  logic        dataShift, dataDone;
  logic        replyLoad, replyShift, replyDone;
  logic [31:0] addrWord, dataWord, replyWord;

  assign frameStart = (state == ST_IDLE) && rxValid && pause &&
                      ((rxData == CMD_WRITE) || (rxData == CMD_READ));
  assign addrShift  = (state == ST_ADDR) && rxValid;
  assign dataShift  = (state == ST_DATA) && rxValid;
  assign replyLoad  = (state == ST_READ_CAPTURE);
  assign replyShift = (state == ST_SEND) && txValid && txReady;

  byte_shift_assembler uAddr (
    .clk(clk), .rst(rst), .clear(frameStart), .load(1'b0), .loadValue(32'h0),
    .shiftEn(addrShift), .shiftIn(rxData), .word(addrWord), .done(addrDone)
  );

  byte_shift_assembler uData (
    .clk(clk), .rst(rst), .clear(frameStart), .load(1'b0), .loadValue(32'h0),
    .shiftEn(dataShift), .shiftIn(rxData), .word(dataWord), .done(dataDone)
  );

  byte_shift_assembler uReply (
    .clk(clk), .rst(rst), .clear(1'b0), .load(replyLoad), .loadValue(externalDataOut),
    .shiftEn(replyShift), .shiftIn(8'h00), .word(replyWord), .done(replyDone)
  );

  assign externalAddress = addrWord;
  assign externalData    = dataWord;
  assign busy            = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                 <= ST_IDLE;
      pause                 <= START_PAUSED;
      externalMemoryControl <= 1'b0;
      externalReadMode      <= MODE_NONE;
      externalWriteMode     <= MODE_NONE;
      txValid               <= 1'b0;
      txData                <= 8'h00;
      overrun               <= 1'b0;
      timer                 <= '0;
      isWrite               <= 1'b0;
    end else begin
      overrun <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rxValid) begin
            if (rxData == CMD_PAUSE || rxData == CMD_GO) begin
              pause   <= (rxData == CMD_PAUSE);
              txData  <= ACK_BYTE;
              txValid <= 1'b1;
              state   <= ST_ACK;
            end else if (frameStart) begin
              isWrite <= (rxData == CMD_WRITE);
              timer   <= TIMER_LOAD;
              state   <= ST_ADDR;
            end else begin
              // Unknown byte, or W/R while the processor runs: memory stays untouched.
              txData  <= NAK_BYTE;
              txValid <= 1'b1;
              state   <= ST_NAK;
            end
          end
        end
        ST_ADDR: begin
          if (rxValid) begin
            timer <= TIMER_LOAD;
            if (addrDone) begin
              if (isWrite) begin
                state <= ST_DATA;
              end else begin
                externalMemoryControl <= 1'b1;
                externalReadMode      <= MODE_WORD;
                state                 <= ST_READ_ISSUE;
              end
            end
          end else if (timer == '0) begin
            txData  <= NAK_BYTE;
            txValid <= 1'b1;
            state   <= ST_NAK;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ST_DATA: begin
          if (rxValid) begin
            timer <= TIMER_LOAD;
            if (dataDone) begin
              externalMemoryControl <= 1'b1;
              externalWriteMode     <= MODE_WORD;
              state                 <= ST_WRITE;
            end
          end else if (timer == '0) begin
            txData  <= NAK_BYTE;
            txValid <= 1'b1;
            state   <= ST_NAK;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ST_WRITE: begin
          externalMemoryControl <= 1'b0;
          externalWriteMode     <= MODE_NONE;
          txData                <= ACK_BYTE;
          txValid               <= 1'b1;
          state                 <= ST_ACK;
        end
        ST_READ_ISSUE: begin
          state <= ST_READ_CAPTURE;
        end
        ST_READ_CAPTURE: begin
          externalMemoryControl <= 1'b0;
          externalReadMode      <= MODE_NONE;
          txData                <= externalDataOut[31:24];
          txValid               <= 1'b1;
          state                 <= ST_SEND;
        end
        ST_SEND: begin
          if (txReady) begin
            if (replyDone) begin
              txValid <= 1'b0;
              state   <= ST_IDLE;
            end else begin
              txData <= replyWord[23:16];
            end
          end
        end
        ST_ACK, ST_NAK: begin
          if (txReady) begin
            txValid <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (rxValid && !(state inside {ST_IDLE, ST_ADDR, ST_DATA})) overrun <= 1'b1;
    end
  end

endmodule
